// File: rtl/a2d_pkg.sv
// a2d_pkg: shared constants and state type for the A2D SPI responder
package a2d_pkg;
    localparam int FRAME_BITS = 16;
    localparam int CMD_LSB    = 11;
    localparam int CHNL_W     = 3;
    localparam int RES_W      = 12;
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} resp_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage synchronizer with rise/fall pulses on the synchronized value
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    // sr[STAGES-1] is the synchronized value, sr[STAGES] its previous cycle
    logic [STAGES:0] sr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= {(STAGES+1){RST_VAL}};
        else sr <= {sr[STAGES-1:0], d};
    assign rise = sr[STAGES-1] & ~sr[STAGES];
    assign fall = ~sr[STAGES-1] & sr[STAGES];
endmodule

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI responder emulating an 8-channel 12-bit A2D with a loadable channel bank
module a2d_spi_resp
    import a2d_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter logic [RES_W-1:0] DFLT_VAL    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              wr_en,
    input  logic [CHNL_W-1:0] wr_chnnl,
    input  logic [RES_W-1:0]  wr_data,
    output logic              cmd_vld,
    output logic [CHNL_W-1:0] cmd_chnnl,
    output logic              frm_err
);
    resp_state_t            state, state_nxt;
    logic [FRAME_BITS-1:0]  shft_reg;
    logic [4:0]             bit_cnt;
    logic [RES_W-1:0]       bank [2**CHNL_W];
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic ss_rise, ss_fall, sclk_rise, sclk_fall_unused;
    logic load, shift, frame_ok;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst_n(rst_n), .d(SS_n), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(SCLK), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mosi_sr <= '0;
        else mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int i = 0; i < 2**CHNL_W; i++) bank[i] <= DFLT_VAL;
        else if (wr_en) bank[wr_chnnl] <= wr_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        load      = state == IDLE && ss_fall;
        shift     = state == SHIFT && sclk_rise && !ss_rise;
        frame_ok  = bit_cnt == 5'(FRAME_BITS);
        state_nxt = load ? SHIFT :
                    (state == SHIFT && ss_rise) ? FINISH :
                    (state == FINISH) ? IDLE : state;
    end

    // Response is loaded from the channel of the previous valid frame
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            shft_reg  <= '0;
            bit_cnt   <= '0;
            cmd_chnnl <= '0;
            cmd_vld   <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            cmd_vld <= state == FINISH && frame_ok;
            frm_err <= state == FINISH && !frame_ok;
            if (state == FINISH && frame_ok) cmd_chnnl <= shft_reg[CMD_LSB +: CHNL_W];
            if (load) begin
                shft_reg <= {{(FRAME_BITS-RES_W){1'b0}}, bank[cmd_chnnl]};
                bit_cnt  <= '0;
            end else if (shift) begin
                shft_reg <= {shft_reg[FRAME_BITS-2:0], mosi_sr[SYNC_STAGES-1]};
                bit_cnt  <= bit_cnt + 5'(bit_cnt != 5'd31);
            end
        end

    assign MISO = state == SHIFT && shft_reg[FRAME_BITS-1];
endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb_a2d_spi_resp: directed table-driven bench for the A2D SPI responder
module tb_a2d_spi_resp;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n, SS_n, SCLK, MOSI, MISO, wr_en, cmd_vld, frm_err;
    logic [2:0]  wr_chnnl, cmd_chnnl;
    logic [11:0] wr_data;
    int          n_chk = 0, n_fail = 0, vld_cnt = 0, err_cnt = 0;

    typedef struct {
        logic [15:0] mosi;
        int          nbits;
        logic [15:0] exp_rd;
        int          exp_vld;
        int          exp_err;
        logic [2:0]  exp_ch;
    } vec_t;
    vec_t vecs [9];

    a2d_spi_resp #(.SYNC_STAGES(2), .DFLT_VAL(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .wr_en(wr_en), .wr_chnnl(wr_chnnl), .wr_data(wr_data),
        .cmd_vld(cmd_vld), .cmd_chnnl(cmd_chnnl), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_vld) vld_cnt <= vld_cnt + 1;
        if (frm_err) err_cnt <= err_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bank_wr(input logic [2:0] ch, input logic [11:0] val);
        wr_en = 1'b1; wr_chnnl = ch; wr_data = val;
        wait_clk(1);
        wr_en = 1'b0;
    endtask

    // Master: drives MOSI on SCLK fall, samples MISO just before SCLK rise
    task automatic frame(input logic [15:0] w, input int nbits, input int wr_at,
                         input logic [2:0] wch, input logic [11:0] wval, output logic [15:0] rd);
        rd = '0;
        SS_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? w[15-i] : 1'b0;
            if (i == wr_at) bank_wr(wch, wval);
            wait_clk(HALF);
            if (i < 16) rd[15-i] = MISO;
            SCLK = 1'b1;
            wait_clk(HALF);
        end
        SS_n = 1'b1;
        wait_clk(12);
    endtask

    initial begin
        logic [15:0] rd;
        logic [11:0] mx;
        int v0, e0;
        vecs[0] = '{16'h1800, 16, 16'h0123, 1, 0, 3'd3};
        vecs[1] = '{16'h3000, 16, 16'h0A5C, 1, 0, 3'd6};
        vecs[2] = '{16'hD7FF, 16, 16'h03F1, 1, 0, 3'd2};
        vecs[3] = '{16'h3800,  9, 16'h0000, 0, 1, 3'd2};
        vecs[4] = '{16'h0000, 16, 16'h0001, 1, 0, 3'd0};
        vecs[5] = '{16'h3800, 20, 16'h0000, 0, 1, 3'd0};
        vecs[6] = '{16'h3800,  0, 16'h0000, 0, 1, 3'd0};
        vecs[7] = '{16'h3800, 16, 16'h0123, 1, 0, 3'd7};
        vecs[8] = '{16'h0800, 16, 16'h0000, 1, 0, 3'd1};

        rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        wr_en = 1'b0; wr_chnnl = '0; wr_data = '0;
        wait_clk(3);
        chk("rst MISO", 32'(MISO), 0);
        chk("rst cmd_vld", 32'(cmd_vld), 0);
        chk("rst frm_err", 32'(frm_err), 0);
        chk("rst cmd_chnnl", 32'(cmd_chnnl), 0);
        rst_n = 1'b1;
        wait_clk(3);

        bank_wr(3'd0, 12'h123);
        bank_wr(3'd2, 12'h001);
        bank_wr(3'd3, 12'hA5C);
        bank_wr(3'd6, 12'h3F1);

        foreach (vecs[k]) begin
            v0 = vld_cnt; e0 = err_cnt;
            frame(vecs[k].mosi, vecs[k].nbits, -1, 3'd0, 12'h0, rd);
            if (vecs[k].nbits == 16) chk($sformatf("vec%0d miso", k), 32'(rd), 32'(vecs[k].exp_rd));
            chk($sformatf("vec%0d cmd_vld", k), vld_cnt - v0, vecs[k].exp_vld);
            chk($sformatf("vec%0d frm_err", k), err_cnt - e0, vecs[k].exp_err);
            chk($sformatf("vec%0d cmd_chnnl", k), 32'(cmd_chnnl), 32'(vecs[k].exp_ch));
        end

        // Write to the entry being streamed must not disturb the frame in flight
        frame(16'h1000, 16, -1, 3'd0, 12'h0, rd);
        chk("wr setup cmd_chnnl", 32'(cmd_chnnl), 2);
        frame(16'h1000, 16, 5, 3'd2, 12'hFFF, rd);
        chk("wr mid-frame old value", 32'(rd), 32'h0001);
        frame(16'h1000, 16, -1, 3'd0, 12'h0, rd);
        chk("wr next frame new value", 32'(rd), 32'h0FFF);

        // Reset seven bits into a frame
        SS_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 7; i++) begin
            SCLK = 1'b0; MOSI = 1'b1; wait_clk(HALF);
            SCLK = 1'b1; wait_clk(HALF);
        end
        rst_n = 1'b0;
        wait_clk(2);
        chk("midrst MISO", 32'(MISO), 0);
        chk("midrst cmd_chnnl", 32'(cmd_chnnl), 0);
        chk("midrst state", 32'(dut.state), 32'(a2d_pkg::IDLE));
        SS_n = 1'b1; MOSI = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(3);
        bank_wr(3'd0, 12'h123);
        v0 = vld_cnt;
        frame(16'h3000, 16, -1, 3'd0, 12'h0, rd);
        chk("post-rst miso ch0", 32'(rd), 32'h0123);
        chk("post-rst cmd_vld", vld_cnt - v0, 1);
        chk("post-rst cmd_chnnl", 32'(cmd_chnnl), 6);

        // Master-style command/read pairs over all channels
        for (int c = 0; c < 8; c++) bank_wr(3'(c), 12'(16 * (c + 1)));
        mx = '0;
        for (int c = 0; c < 8; c++) begin
            frame({2'b00, 3'(c), 11'h000}, 16, -1, 3'd0, 12'h0, rd);
            frame({2'b00, 3'(c), 11'h000}, 16, -1, 3'd0, 12'h0, rd);
            chk($sformatf("e2e ch%0d", c), 32'(rd), 32'(16 * (c + 1)));
            if (rd[11:0] > mx) mx = rd[11:0];
        end
        chk("e2e max", 32'(mx), 32'h080);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
